// File: rtl/pixel_stream_reader.sv
// Raster-order frame source: reads IMG_W*IMG_H pixels from a 1-cycle-latency memory
// and emits them as a valid/ready stream with coordinates and frame markers.
module pixel_stream_reader #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned X_W    = 8,
  parameter int unsigned Y_W    = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [PIX_W-1:0]  i_mem_rdata,
  output logic [PIX_W-1:0]  o_pixel_out,
  output logic [X_W-1:0]    o_pixel_x,
  output logic [Y_W-1:0]    o_pixel_y,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_eof,
  output logic              o_pixel_valid,
  input  logic              i_pixel_ready
);

  localparam logic [X_W-1:0]    LAST_X    = X_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           sof;
    logic           eol;
    logic           eof;
  } tag_t;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    tag_t             tag;
  } beat_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FINISH
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [X_W-1:0]      r_x;
  logic [X_W-1:0]      w_x_nxt;
  logic [Y_W-1:0]      r_y;
  logic [Y_W-1:0]      w_y_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_rd_en;

  logic                r_inflight;
  tag_t                r_if_tag;
  tag_t                w_issue_tag;
  beat_t               w_push_beat;

  beat_t               r_head;
  logic                r_head_v;
  beat_t               r_skid;
  logic                r_skid_v;
  logic                r_done;

  logic                w_pop;
  logic [1:0]          w_occ;
  logic                w_room;

  // Occupancy counts stored beats plus the read returning this cycle
  assign w_pop  = r_head_v & i_pixel_ready;
  assign w_occ  = 2'(r_head_v) + 2'(r_skid_v) + 2'(r_inflight);
  assign w_room = (w_occ - 2'(w_pop)) < 2'd2;

  assign w_issue_tag.x   = r_x;
  assign w_issue_tag.y   = r_y;
  assign w_issue_tag.sof = (r_x == '0) && (r_y == '0);
  assign w_issue_tag.eol = (r_x == LAST_X);
  assign w_issue_tag.eof = (r_addr == LAST_ADDR);

  assign w_push_beat.pix = i_mem_rdata;
  assign w_push_beat.tag = r_if_tag;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, read issue and raster counters
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_addr_nxt  = r_addr;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_STREAM;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_addr_nxt  = '0;
        end
      end
      S_STREAM: begin
        if (w_room) begin
          w_rd_en = 1'b1;
          if (r_addr == LAST_ADDR) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_addr_nxt = r_addr + ADDR_W'(1);
            if (r_x == LAST_X) begin
              w_x_nxt = '0;
              w_y_nxt = r_y + Y_W'(1);
            end else begin
              w_x_nxt = r_x + X_W'(1);
            end
          end
        end
      end
      S_FINISH: begin
        if (w_pop && r_head.tag.eof) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counters, in-flight tag, done pulse and the two-entry output buffer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_if_tag   <= '0;
      r_head     <= '0;
      r_head_v   <= 1'b0;
      r_skid     <= '0;
      r_skid_v   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_addr     <= w_addr_nxt;
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_if_tag <= w_issue_tag;
      end
      r_done <= (r_state == S_FINISH) && w_pop && r_head.tag.eof;

      if (w_pop) begin
        if (r_skid_v) begin
          r_head   <= r_skid;
          r_head_v <= 1'b1;
          r_skid_v <= r_inflight;
          if (r_inflight) begin
            r_skid <= w_push_beat;
          end
        end else begin
          r_head_v <= r_inflight;
          if (r_inflight) begin
            r_head <= w_push_beat;
          end
        end
      end else if (r_inflight) begin
        if (!r_head_v) begin
          r_head   <= w_push_beat;
          r_head_v <= 1'b1;
        end else begin
          r_skid   <= w_push_beat;
          r_skid_v <= 1'b1;
        end
      end
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_mem_rd_en   = w_rd_en;
  assign o_mem_addr    = r_addr;
  assign o_pixel_out   = r_head.pix;
  assign o_pixel_x     = r_head.tag.x;
  assign o_pixel_y     = r_head.tag.y;
  assign o_sof         = r_head.tag.sof;
  assign o_eol         = r_head.tag.eol;
  assign o_eof         = r_head.tag.eof;
  assign o_pixel_valid = r_head_v;

endmodule

// File: tb/tb_pixel_stream_reader.sv
// Directed bench for pixel_stream_reader: a 4x2 frame under several ready/start/reset
// patterns, plus a 1x1 frame on a second instance.
module tb_pixel_stream_reader;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 8;
  localparam int unsigned ADDR_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, ready_a, start_b, ready_b;

  logic              a_busy, a_done, a_rd_en, a_sof, a_eol, a_eof, a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [PIX_W-1:0]  a_rdata, a_pix;
  logic [X_W-1:0]    a_x;
  logic [Y_W-1:0]    a_y;

  logic              b_busy, b_done, b_rd_en, b_sof, b_eol, b_eof, b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [PIX_W-1:0]  b_rdata, b_pix;
  logic [X_W-1:0]    b_x;
  logic [Y_W-1:0]    b_y;

  pixel_stream_reader #(.IMG_W(4), .IMG_H(2), .PIX_W(PIX_W), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .o_busy(a_busy), .o_done(a_done),
    .o_mem_rd_en(a_rd_en), .o_mem_addr(a_addr), .i_mem_rdata(a_rdata),
    .o_pixel_out(a_pix), .o_pixel_x(a_x), .o_pixel_y(a_y), .o_sof(a_sof), .o_eol(a_eol),
    .o_eof(a_eof), .o_pixel_valid(a_valid), .i_pixel_ready(ready_a));

  pixel_stream_reader #(.IMG_W(1), .IMG_H(1), .PIX_W(PIX_W), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .o_busy(b_busy), .o_done(b_done),
    .o_mem_rd_en(b_rd_en), .o_mem_addr(b_addr), .i_mem_rdata(b_rdata),
    .o_pixel_out(b_pix), .o_pixel_x(b_x), .o_pixel_y(b_y), .o_sof(b_sof), .o_eol(b_eol),
    .o_eof(b_eof), .o_pixel_valid(b_valid), .i_pixel_ready(ready_b));

  // Synchronous memories: mem[i] = i + 10 for the 4x2 image, mem[0] = 0xA5 for 1x1
  always @(posedge clk) if (a_rd_en) a_rdata <= PIX_W'(a_addr + 16'd10);
  always @(posedge clk) if (b_rd_en) b_rdata <= (b_addr == '0) ? 8'hA5 : 8'h00;

  typedef struct {
    logic [7:0] pix;
    logic [7:0] x;
    logic [7:0] y;
    logic       sof;
    logic       eol;
    logic       eof;
  } beat_t;

  typedef struct {
    int mode;          // 0: ready high, 1: ready 1,0,0 repeating, 2: ready low for 20 clks
    int restart_beat;  // pulse start after this many beats (-1: never)
    int rst_beat;      // pulse rst after this many beats (-1: never)
    int exp_n;
    bit second;        // run a clean frame afterwards
  } scen_t;

  beat_t exp_beats[8];
  scen_t scens[5];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [26:0] beat_vec(input beat_t b);
    return {b.pix, b.x, b.y, b.sof, b.eol, b.eof};
  endfunction

  function automatic logic [26:0] a_vec();
    return {a_pix, a_x, a_y, a_sof, a_eol, a_eof};
  endfunction

  task automatic chk_a_zero(input string tag);
    chk({tag, "_busy"}, 32'(a_busy), 0);
    chk({tag, "_done"}, 32'(a_done), 0);
    chk({tag, "_valid"}, 32'(a_valid), 0);
    chk({tag, "_rd_en"}, 32'(a_rd_en), 0);
    chk({tag, "_addr"}, 32'(a_addr), 0);
    chk({tag, "_beat"}, 32'(a_vec()), 0);
  endtask

  // Start a frame on instance A at a negedge and follow it cycle by cycle
  task automatic run_frame(input int mode, input int restart_beat, input int rst_beat, input int exp_n);
    int beat = 0;
    int iss = 0;
    int acc = 0;
    int first_v = -1;
    int last_cyc = -1;
    bit stalled = 1'b0;
    bit restart_now = 1'b0;
    bit do_rst = 1'b0;
    bit fin = 1'b0;
    bit pop;
    logic [26:0] prev = '0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      case (mode)
        0:       ready_a = 1'b1;
        1:       ready_a = (cyc % 3 == 0);
        default: ready_a = (cyc > 20);
      endcase
      start_a = restart_now;
      restart_now = 1'b0;
      if (do_rst) begin
        rst = 1'b1;
        ready_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_a_zero("after_rst");
        chk("beats_before_rst", 32'(beat), 32'(rst_beat));
        repeat (8) begin
          @(negedge clk);
          #1;
          chk("post_rst_valid", 32'(a_valid), 0);
          chk("post_rst_done", 32'(a_done), 0);
        end
        return;
      end
      #1;
      if (cyc == 1) begin
        chk("t1_rd_en", 32'(a_rd_en), 1);
        chk("t1_addr", 32'(a_addr), 0);
        chk("t1_busy", 32'(a_busy), 1);
        chk("t1_valid", 32'(a_valid), 0);
      end
      if (a_valid && first_v < 0) begin
        first_v = cyc;
        chk("first_valid_cycle", 32'(cyc), 3);
      end
      if (stalled) begin
        chk("stall_valid_held", 32'(a_valid), 1);
        chk("stall_beat_stable", 32'(a_vec()), 32'(prev));
      end
      pop = a_valid & ready_a;
      if (pop) begin
        acc++;
        if (beat < 8) chk($sformatf("beat%0d", beat), 32'(a_vec()), 32'(beat_vec(exp_beats[beat])));
        else chk("extra_beat", 32'(beat), 32'(exp_n - 1));
        beat++;
        if (beat == restart_beat) restart_now = 1'b1;
        if (beat == rst_beat) do_rst = 1'b1;
        if (beat == exp_n) last_cyc = cyc;
      end
      if (a_rd_en) begin
        iss++;
        chk("outstanding_le_2", 32'(iss - acc <= 2), 1);
      end
      if (mode == 2 && cyc == 20) begin
        chk("stall20_reads", 32'(iss), 2);
        chk("stall20_valid", 32'(a_valid), 1);
        chk("stall20_pix", 32'(a_pix), 10);
      end
      if (last_cyc >= 0 && cyc == last_cyc + 1) begin
        chk("done_pulse", 32'(a_done), 1);
        chk("done_busy", 32'(a_busy), 0);
        chk("done_valid", 32'(a_valid), 0);
        fin = 1'b1;
      end else begin
        chk("done_low", 32'(a_done), 0);
      end
      stalled = a_valid & ~ready_a;
      prev = a_vec();
      if (!fin) @(negedge clk);
    end
    if (!fin) chk("frame_timeout", 0, 1);
    chk("beat_count", 32'(beat), 32'(exp_n));
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("idle_busy", 32'(a_busy), 0);
      chk("idle_valid", 32'(a_valid), 0);
      chk("idle_done", 32'(a_done), 0);
    end
  endtask

  initial begin
    exp_beats[0] = '{8'd10, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0};
    exp_beats[1] = '{8'd11, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0};
    exp_beats[2] = '{8'd12, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0};
    exp_beats[3] = '{8'd13, 8'd3, 8'd0, 1'b0, 1'b1, 1'b0};
    exp_beats[4] = '{8'd14, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0};
    exp_beats[5] = '{8'd15, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0};
    exp_beats[6] = '{8'd16, 8'd2, 8'd1, 1'b0, 1'b0, 1'b0};
    exp_beats[7] = '{8'd17, 8'd3, 8'd1, 1'b0, 1'b1, 1'b1};
    scens[0] = '{0, -1, -1, 8, 1'b0};
    scens[1] = '{1, -1, -1, 8, 1'b0};
    scens[2] = '{0,  4, -1, 8, 1'b1};
    scens[3] = '{0, -1,  3, 8, 1'b1};
    scens[4] = '{2, -1, -1, 8, 1'b0};

    rst = 1'b1;
    start_a = 1'b0;
    ready_a = 1'b0;
    start_b = 1'b0;
    ready_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_a_zero("reset");
    chk("reset_b_busy", 32'(b_busy), 0);
    chk("reset_b_valid", 32'(b_valid), 0);
    @(negedge clk);

    for (int s = 0; s < 5; s++) begin
      run_frame(scens[s].mode, scens[s].restart_beat, scens[s].rst_beat, scens[s].exp_n);
      if (scens[s].second) run_frame(0, -1, -1, 8);
    end

    // 1x1 image on the second instance
    begin
      int reads = 0;
      int got = -1;
      start_b = 1'b1;
      ready_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
        #1;
        if (b_rd_en) reads++;
        if (got >= 0 && cyc == got + 1) begin
          chk("b_done", 32'(b_done), 1);
          chk("b_valid_after", 32'(b_valid), 0);
          chk("b_busy_after", 32'(b_busy), 0);
        end else begin
          chk("b_done_low", 32'(b_done), 0);
        end
        if (b_valid) begin
          if (got < 0) chk("b_first_valid_cycle", 32'(cyc), 3);
          else chk("b_extra_beat", 32'(cyc), 32'(got));
          chk("b_beat", 32'({b_pix, b_x, b_y, b_sof, b_eol, b_eof}), 32'({8'hA5, 8'd0, 8'd0, 3'b111}));
          got = cyc;
        end
        @(negedge clk);
      end
      chk("b_beat_seen", 32'(got >= 0), 1);
      chk("b_reads", 32'(reads), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
